mul8_arb: RTL and testbench
===========================

# mul8_arb

Round-robin arbiter that shares one fixed-latency 8x8 fractional multiplier (result = (a*b)>>8, 8 bits) between NREQ requesters. It sits between the requesting datapath blocks and a single multiplier instance. It accepts operand pairs through a valid/ready handshake and issues at most one pair per cycle. It tracks each in-flight operation's owner through a tag pipeline matched to the multiplier latency, and returns each result to its owner with a one-hot response strobe.

## Interface
- NREQ, 4, number of requesters (2..8)
- MUL_LAT, 1, cycles from operands presented on mul_a_o/mul_b_o to valid mul_p_i (1..4)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  NREQ  requester k has an operand pair
- req_a_i  in  8*NREQ  operand a, requester k at [8k+7:8k]
- req_b_i  in  8*NREQ  operand b, requester k at [8k+7:8k]
- req_ready_o  out  NREQ  grant, at most one bit set
- mul_a_o  out  8  registered operand a to multiplier
- mul_b_o  out  8  registered operand b to multiplier
- mul_vld_o  out  1  mul_a_o/mul_b_o carry an issued operation
- mul_p_i  in  8  multiplier result, (a*b)>>8
- resp_valid_o  out  NREQ  one-hot result strobe, one cycle
- resp_p_o  out  8  result for the requester flagged in resp_valid_o
- busy_o  out  1  any operation in flight

## Operation
- Transfer: a request transfers in a cycle where req_valid_i[k] and req_ready_o[k] are both 1.
- Grant logic: req_ready_o is combinational from req_valid_i and the priority pointer.
  - Requesters must not make req_valid_i depend on req_ready_o.
  - A requester holds valid and operands stable until it is granted.
- Grant selection: search starts at pointer ptr and scans upward, modulo NREQ. The first valid requester is granted. If none is valid, req_ready_o = 0.
- Pointer update: after a grant to k, ptr <= (k+1) mod NREQ. With no grant, ptr is unchanged.
- Issue register: on a transfer, mul_a_o/mul_b_o <= the granted operands and mul_vld_o <= 1. Otherwise mul_vld_o <= 0 and mul_a_o/mul_b_o hold their value.
- Tag pipeline: MUL_LAT+1 stages, each holding {valid, one-hot owner}. It advances every cycle with no stalls, because the response side has no backpressure.
- Response capture: when a tag exits the pipeline, resp_p_o <= mul_p_i and resp_valid_o <= that tag's owner. Otherwise resp_valid_o <= 0 and resp_p_o holds.
- busy_o: 1 while any tag stage or resp_valid_o is set.
- Arithmetic belongs to the multiplier. This block never modifies operands or results.

## Timing
- Reset values: ptr=0, tags cleared, mul_vld_o=0, mul_a_o=mul_b_o=0, resp_valid_o=0, resp_p_o=0, busy_o=0. req_ready_o=0 while rst_n=0.
- Latency: a transfer in cycle n gives:
  - mul_vld_o=1 in cycle n+1;
  - mul_p_i sampled in cycle n+1+MUL_LAT;
  - resp_valid_o in cycle n+2+MUL_LAT (cycle n+3 at MUL_LAT=1).
- Throughput: one transfer per cycle sustained. Back-to-back issues return results in issue order, one per cycle.
- Simultaneous requests: exactly one grant; the rest wait.
- Starvation: with all NREQ requesters valid, grants rotate 0,1,..,NREQ-1,0. Worst-case wait is NREQ-1 cycles.
- Same requester: it may be granted again while its earlier result is still in flight. Its responses arrive in order.
- Pointer wrap: ptr goes from NREQ-1 to 0 with no gap cycle.
- Reset mid-operation: asserting rst_n clears all in-flight tags immediately. No resp_valid_o is produced for operations issued before reset. Outputs take reset values asynchronously.

## Configuration
- MUL8_ARB_RR_EN defined: round-robin pointer as specified above.
- MUL8_ARB_RR_EN undefined: fixed priority; the lowest valid index always wins, ptr logic is removed, and requester 0 can starve others. All latency and response behaviour is otherwise identical.

## Test plan
- Reset, then requester 0 sends a=0x45, b=0x55 in cycle n -> req_ready_o=0001 in cycle n; mul_vld_o=1 in cycle n+1; resp_valid_o=0001 and resp_p_o=0x16 in cycle n+3 (MUL_LAT=1).
- Requester 1 sends 0x55,0x65, then immediately 0xFF,0xFF -> two consecutive responses on resp_valid_o=0010, with resp_p_o 0x21 then 0xFE.
- All four valid and held for 8 cycles (RR_EN defined) -> grant order 0,1,2,3,0,1,2,3, each response routed to the correct one-hot owner.
- Same stimulus with MUL8_ARB_RR_EN undefined -> requester 0 granted every cycle; requesters 1-3 are never granted.
- rst_n pulsed low one cycle after a grant -> no resp_valid_o ever appears for that request; busy_o=0 after reset; next request starts from ptr=0.
- MUL_LAT=3 with a reference multiplier model -> each response appears 5 cycles after its grant cycle, and values match (a*b)>>8 for random operands.

Source files
------------

// File: rtl/mul8_arb.sv
// Shares one fixed-latency 8x8 fractional multiplier among NREQ requesters and routes each result back to its owner.
// MUL8_ARB_RR_EN defined: round-robin grants from a rotating pointer; undefined: fixed lowest-index priority.
module mul8_arb #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_a_i,
  input  logic [8*NREQ-1:0] req_b_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [7:0]        mul_a_o,
  output logic [7:0]        mul_b_o,
  output logic              mul_vld_o,
  input  logic [7:0]        mul_p_i,
  output logic [NREQ-1:0]   resp_valid_o,
  output logic [7:0]        resp_p_o,
  output logic              busy_o
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            any_grant;
  logic [PW-1:0]   gidx;
  logic [NREQ-1:0] grant;
  logic [7:0]      ga;
  logic [7:0]      gb;
  logic [NREQ-1:0] tag_q [MUL_LAT+1];

`ifdef MUL8_ARB_RR_EN
  logic [PW-1:0] ptr;
  logic [PW:0]   scan;

  // Scan upward from ptr, wrapping modulo NREQ; first valid requester wins.
  always_comb begin
    any_grant = 1'b0;
    gidx      = '0;
    scan      = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan = (PW+1)'(ptr) + (PW+1)'(i);
      if (scan >= (PW+1)'(NREQ)) scan = scan - (PW+1)'(NREQ);
      if (!any_grant && req_valid_i[scan[PW-1:0]]) begin
        any_grant = 1'b1;
        gidx      = scan[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
    end
  end
`else
  // Downward scan leaves the lowest valid index as the winner.
  always_comb begin
    any_grant = 1'b0;
    gidx      = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        any_grant = 1'b1;
        gidx      = PW'(i);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    ga    = '0;
    gb    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (any_grant && gidx == PW'(k)) begin
        grant[k] = 1'b1;
        ga       = req_a_i[8*k +: 8];
        gb       = req_b_i[8*k +: 8];
      end
    end
  end

  assign req_ready_o = rst_n ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_o   <= '0;
      mul_b_o   <= '0;
      mul_vld_o <= 1'b0;
    end else if (any_grant) begin
      mul_a_o   <= ga;
      mul_b_o   <= gb;
      mul_vld_o <= 1'b1;
    end else begin
      mul_vld_o <= 1'b0;
    end
  end

  // Owner tags ride alongside the multiplier; an all-zero tag marks an empty slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= MUL_LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= grant;
      for (int s = 1; s <= MUL_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_o <= '0;
      resp_p_o     <= '0;
    end else if (|tag_q[MUL_LAT]) begin
      resp_valid_o <= tag_q[MUL_LAT];
      resp_p_o     <= mul_p_i;
    end else begin
      resp_valid_o <= '0;
    end
  end

  always_comb begin
    busy_o = |resp_valid_o;
    for (int s = 0; s <= MUL_LAT; s++) busy_o = busy_o | (|tag_q[s]);
  end

endmodule

// File: tb/tb_mul8_arb.sv
// Scoreboard bench for mul8_arb: one instance at MUL_LAT=1, one at MUL_LAT=3, each fed by a behavioural multiplier.
`timescale 1ns/1ps
module tb_mul8_arb;
  localparam int NREQ = 4;

  typedef struct {
    int         owner;
    logic [7:0] p;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t sb3[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = {8'h00, a} * {8'h00, b};
    return p[15:8];
  endfunction

  // MUL_LAT=1 instance
  logic [NREQ-1:0]   req_valid;
  logic [7:0]        opa [NREQ];
  logic [7:0]        opb [NREQ];
  logic [8*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        mul_a, mul_b, mul_p;
  logic              mul_vld;
  logic [NREQ-1:0]   resp_valid;
  logic [7:0]        resp_p;
  logic              busy;

  // MUL_LAT=3 instance
  logic [NREQ-1:0]   req_valid3;
  logic [7:0]        opa3 [NREQ];
  logic [7:0]        opb3 [NREQ];
  logic [8*NREQ-1:0] req_a3, req_b3;
  logic [NREQ-1:0]   req_ready3;
  logic [7:0]        mul_a3, mul_b3, mul_p3;
  logic              mul_vld3;
  logic [NREQ-1:0]   resp_valid3;
  logic [7:0]        resp_p3;
  logic              busy3;
  logic [7:0]        mpipe3 [3];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_a[8*g +: 8]  = opa[g];
    assign req_b[8*g +: 8]  = opb[g];
    assign req_a3[8*g +: 8] = opa3[g];
    assign req_b3[8*g +: 8] = opb3[g];
  end

  always @(posedge clk) mul_p <= ref_mul(mul_a, mul_b);

  always @(posedge clk) begin
    mpipe3[0] <= ref_mul(mul_a3, mul_b3);
    mpipe3[1] <= mpipe3[0];
    mpipe3[2] <= mpipe3[1];
  end
  assign mul_p3 = mpipe3[2];

  mul8_arb #(.NREQ(NREQ), .MUL_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(req_ready),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_vld_o(mul_vld), .mul_p_i(mul_p),
    .resp_valid_o(resp_valid), .resp_p_o(resp_p), .busy_o(busy)
  );

  mul8_arb #(.NREQ(NREQ), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid3), .req_a_i(req_a3), .req_b_i(req_b3), .req_ready_o(req_ready3),
    .mul_a_o(mul_a3), .mul_b_o(mul_b3), .mul_vld_o(mul_vld3), .mul_p_i(mul_p3),
    .resp_valid_o(resp_valid3), .resp_p_o(resp_p3), .busy_o(busy3)
  );

  // Scoreboard for the MUL_LAT=1 instance: push on transfer, pop on response.
  exp_t mon_e;
  logic [NREQ-1:0] mon_oh;
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(req_ready) > 1) begin
        fails++;
        $display("FAIL grant_onehot: req_ready=%b, required at most one bit set", req_ready);
      end
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          mon_e.owner = k;
          mon_e.p     = ref_mul(opa[k], opb[k]);
          mon_e.due   = cyc + 3;
          sb.push_back(mon_e);
        end
      end
      if (resp_valid != '0) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: resp_valid=%b resp_p=%h, required no response", resp_valid, resp_p);
        end else begin
          mon_e  = sb.pop_front();
          mon_oh = '0;
          mon_oh[mon_e.owner] = 1'b1;
          if (resp_valid !== mon_oh || resp_p !== mon_e.p || cyc != mon_e.due) begin
            fails++;
            $display("FAIL sb_resp: got owner=%b p=%h cycle=%0d, required owner=%b p=%h cycle=%0d",
                     resp_valid, resp_p, cyc, mon_oh, mon_e.p, mon_e.due);
          end
        end
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    sb3.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d responses outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid  = '1;
    req_valid3 = '0;
    for (int k = 0; k < NREQ; k++) begin
      opa[k] = 8'hFF; opb[k] = 8'hFF; opa3[k] = 8'h00; opb3[k] = 8'h00;
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
    checks++;
    if (mul_vld !== 1'b0 || mul_a !== 8'h00 || mul_b !== 8'h00) begin
      fails++; $display("FAIL reset_issue: got vld=%b a=%h b=%h, required 0 00 00", mul_vld, mul_a, mul_b);
    end
    checks++;
    if (resp_valid !== 4'b0000 || resp_p !== 8'h00) begin
      fails++; $display("FAIL reset_resp: got valid=%b p=%h, required 0000 00", resp_valid, resp_p);
    end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    req_valid = 4'b0001; opa[0] = 8'h45; opb[0] = 8'h55;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL basic_grant: got %b, required 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (mul_vld !== 1'b1 || mul_a !== 8'h45 || mul_b !== 8'h55) begin
      fails++; $display("FAIL basic_issue: got vld=%b a=%h b=%h, required 1 45 55", mul_vld, mul_a, mul_b);
    end
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b, required 1", busy); end
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0000) begin fails++; $display("FAIL basic_early: got %b, required 0000", resp_valid); end
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0001 || resp_p !== 8'h16) begin
      fails++; $display("FAIL basic_resp: got %b %h, required 0001 16", resp_valid, resp_p);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0000 || resp_p !== 8'h16 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_after: got valid=%b p=%h busy=%b, required 0000 16 0", resp_valid, resp_p, busy);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    req_valid = 4'b0010; opa[1] = 8'h55; opb[1] = 8'h65;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin fails++; $display("FAIL b2b_grant0: got %b, required 0010", req_ready); end
    @(posedge clk); #1;
    opa[1] = 8'hFF; opb[1] = 8'hFF;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin fails++; $display("FAIL b2b_grant1: got %b, required 0010", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0010 || resp_p !== 8'h21) begin
      fails++; $display("FAIL b2b_resp0: got %b %h, required 0010 21", resp_valid, resp_p);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0010 || resp_p !== 8'hFE) begin
      fails++; $display("FAIL b2b_resp1: got %b %h, required 0010 fe", resp_valid, resp_p);
    end
    drain("b2b");
  endtask

  task automatic test_rotation();
    int exp_k;
    logic [NREQ-1:0] exp_oh;
    reset_dut();
    @(posedge clk); #1;
    for (int k = 0; k < NREQ; k++) begin
      opa[k] = 8'($urandom_range(0, 255)); opb[k] = 8'($urandom_range(0, 255));
    end
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef MUL8_ARB_RR_EN
      exp_k = i % NREQ;
`else
      exp_k = 0;
`endif
      exp_oh = '0;
      exp_oh[exp_k] = 1'b1;
      checks++;
      if (req_ready !== exp_oh) begin
        fails++; $display("FAIL rotate_grant%0d: got %b, required %b", i, req_ready, exp_oh);
      end
      @(posedge clk); #1;
      opa[exp_k] = 8'($urandom_range(0, 255)); opb[exp_k] = 8'($urandom_range(0, 255));
    end
    req_valid = '0;
    drain("rotate");
  endtask

  task automatic test_reset_mid();
    reset_dut();
    @(posedge clk); #1;
    req_valid = 4'b0100; opa[2] = 8'hC3; opb[2] = 8'h9A;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin fails++; $display("FAIL rstmid_grant: got %b, required 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (mul_vld !== 1'b0 || busy !== 1'b0 || resp_valid !== 4'b0000) begin
      fails++; $display("FAIL rstmid_async: got vld=%b busy=%b resp=%b, required 0 0 0000", mul_vld, busy, resp_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 4'b0000) begin fails++; $display("FAIL rstmid_ghost: got %b, required 0000", resp_valid); end
    end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    @(posedge clk); #1;
    req_valid = 4'b1010; opa[1] = 8'h80; opb[1] = 8'h80; opa[3] = 8'h7F; opb[3] = 8'h02;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin fails++; $display("FAIL rstmid_ptr0: got %b, required 0010", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin fails++; $display("FAIL rstmid_next: got %b, required 1000", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    drain("rstmid");
  endtask

  task automatic test_mul_lat3();
    exp_t e;
    int k;
    logic [NREQ-1:0] oh;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (c < 24 && $urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, NREQ-1);
        opa3[k] = 8'($urandom_range(0, 255));
        opb3[k] = 8'($urandom_range(0, 255));
        req_valid3 = '0;
        req_valid3[k] = 1'b1;
      end else begin
        req_valid3 = '0;
      end
      @(negedge clk);
      if (req_valid3 != '0) begin
        checks++;
        if (req_ready3 !== req_valid3) begin
          fails++; $display("FAIL lat3_grant: got %b, required %b", req_ready3, req_valid3);
        end
        e.owner = k;
        e.p     = ref_mul(opa3[k], opb3[k]);
        e.due   = cyc + 5;
        sb3.push_back(e);
      end
      if (resp_valid3 != '0) begin
        checks++;
        if (sb3.size() == 0) begin
          fails++; $display("FAIL lat3_unexpected: got %b %h, required no response", resp_valid3, resp_p3);
        end else begin
          e  = sb3.pop_front();
          oh = '0;
          oh[e.owner] = 1'b1;
          if (resp_valid3 !== oh || resp_p3 !== e.p || cyc != e.due) begin
            fails++;
            $display("FAIL lat3_resp: got owner=%b p=%h cycle=%0d, required owner=%b p=%h cycle=%0d",
                     resp_valid3, resp_p3, cyc, oh, e.p, e.due);
          end
        end
      end
    end
    checks++;
    if (sb3.size() != 0) begin fails++; $display("FAIL lat3_drain: %0d outstanding, required 0", sb3.size()); end
    checks++;
    if (busy3 !== 1'b0) begin fails++; $display("FAIL lat3_busy: got %b, required 0", busy3); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_rotation();
    test_reset_mid();
    test_mul_lat3();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
